// File: rtl/pla_br2_result_buf.sv
// ---------------------------------------------------------------------------
// pla_br2_result_buf
//
// Four-entry result FIFO behind the br2 decode PLA. Each stored result gets a
// 4-bit sequence tag so that downstream logic can spot gaps. When filter_zero
// is high on the accepting edge, all-zero results are dropped instead of
// stored, and a saturating drop counter records them.
//
// Optional feature macro: PLA_BR2_PARITY_EN
//    When defined, each entry keeps an odd-parity bit (XOR of its 8 data bits,
//    computed at write), presented on out_par for the head entry.
//
// Ports
//    clk          in   1  sole clock, rising edge
//    rst          in   1  synchronous active-high reset
//    in_valid     in   1  in_z holds a PLA result
//    in_z         in   8  PLA outputs z7..z0 (z0 is bit 0)
//    in_ready     out  1  buffer can accept this cycle (occupancy < 4)
//    filter_zero  in   1  discard all-zero results instead of storing them
//    out_valid    out  1  head entry valid (occupancy > 0)
//    out_z        out  8  head entry data, 0 when empty
//    out_seq      out  4  head entry sequence tag, 0 when empty
//    out_ready    in   1  downstream consumes the head entry
//    drop_cnt     out  8  saturating count of filtered all-zero results
//    out_par      out  1  parity of head entry (PLA_BR2_PARITY_EN only)
// ---------------------------------------------------------------------------
module pla_br2_result_buf (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_z,
   output logic       in_ready,
   input  logic       filter_zero,
   output logic       out_valid,
   output logic [7:0] out_z,
   output logic [3:0] out_seq,
   input  logic       out_ready,
   output logic [7:0] drop_cnt
`ifdef PLA_BR2_PARITY_EN
   ,
   output logic       out_par
`endif
);

   // Control state
   logic [2:0] occ_q,  occ_d;
   logic [1:0] head_q, head_d;
   logic [1:0] tail_q, tail_d;
   logic [3:0] seq_q,  seq_d;
   logic [7:0] drop_q, drop_d;

   // Entry storage; not reset, the empty case is masked at the outputs
   logic [7:0] data_q [4];
   logic [3:0] tag_q  [4];
`ifdef PLA_BR2_PARITY_EN
   logic [3:0] par_q;
`endif

   logic accept;
   logic is_drop;
   logic store;
   logic pop;

   // Occupancy < 4 is simply bit 2 clear, since occupancy never exceeds 4
   assign in_ready  = ~occ_q[2];
   assign out_valid = (occ_q != 3'd0);

   assign accept  = in_valid & in_ready;
   // filter_zero only matters on the accepting edge
   assign is_drop = accept & filter_zero & (in_z == 8'h00);
   assign store   = accept & ~is_drop;
   assign pop     = out_valid & out_ready;

   always_comb begin
      occ_d  = occ_q + {2'b00, store} - {2'b00, pop};
      head_d = pop   ? head_q + 2'd1 : head_q;
      tail_d = store ? tail_q + 2'd1 : tail_q;
      seq_d  = store ? seq_q  + 4'd1 : seq_q;
      drop_d = (is_drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q  <= 3'd0;
         head_q <= 2'd0;
         tail_q <= 2'd0;
         seq_q  <= 4'd0;
         drop_q <= 8'd0;
      end else begin
         occ_q  <= occ_d;
         head_q <= head_d;
         tail_q <= tail_d;
         seq_q  <= seq_d;
         drop_q <= drop_d;
      end
   end

   // Writes are suppressed during reset so a handshake in that cycle is ignored
   always_ff @(posedge clk) begin
      if (store && !rst) begin
         data_q[tail_q] <= in_z;
         tag_q[tail_q]  <= seq_q;
      end
   end

`ifdef PLA_BR2_PARITY_EN
   always_ff @(posedge clk) begin
      if (store && !rst) begin
         par_q[tail_q] <= ^in_z;
      end
   end

   assign out_par = out_valid ? par_q[head_q] : 1'b0;
`endif

   assign out_z    = out_valid ? data_q[head_q] : 8'h00;
   assign out_seq  = out_valid ? tag_q[head_q]  : 4'h0;
   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_pla_br2_result_buf.sv
module tb_pla_br2_result_buf;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_z;
   logic       in_ready;
   logic       filter_zero;
   logic       out_valid;
   logic [7:0] out_z;
   logic [3:0] out_seq;
   logic       out_ready;
   logic [7:0] drop_cnt;
`ifdef PLA_BR2_PARITY_EN
   logic       out_par;
`endif

   pla_br2_result_buf dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_z        (in_z),
      .in_ready    (in_ready),
      .filter_zero (filter_zero),
      .out_valid   (out_valid),
      .out_z       (out_z),
      .out_seq     (out_seq),
      .out_ready   (out_ready),
      .drop_cnt    (drop_cnt)
`ifdef PLA_BR2_PARITY_EN
      ,
      .out_par     (out_par)
`endif
   );

   always #5 clk = ~clk;

   // Scoreboard: {tag, data} of each stored word, oldest first
   logic [11:0] sb_q[$];
   logic [3:0]  m_seq;
   logic [7:0]  m_drop;
   int          n_vec;
   int          n_err;
   bit          chk_en;

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive at the falling edge, check the state left by the
   // previous rising edge, then advance the model through the next one.
   task automatic cycle(input logic r, input logic v, input logic [7:0] z,
                        input logic fz, input logic ordy);
      logic [11:0] head;
      @(negedge clk);
      rst         = r;
      in_valid    = v;
      in_z        = z;
      filter_zero = fz;
      out_ready   = ordy;
      if (chk_en) begin
         check_val("in_ready",  in_ready,  sb_q.size() < 4);
         check_val("out_valid", out_valid, sb_q.size() > 0);
         check_val("drop_cnt",  drop_cnt,  m_drop);
         head = (sb_q.size() > 0) ? sb_q[0] : 12'h000;
         check_val("out_z",   out_z,   head[7:0]);
         check_val("out_seq", out_seq, head[11:8]);
`ifdef PLA_BR2_PARITY_EN
         check_val("out_par", out_par, (sb_q.size() > 0) ? ^head[7:0] : 1'b0);
`endif
      end
      if (r) begin
         sb_q.delete();
         m_seq  = 4'd0;
         m_drop = 8'd0;
      end else begin
         bit acc;
         acc = v && (sb_q.size() < 4);
         if (ordy && sb_q.size() > 0) void'(sb_q.pop_front());
         if (acc) begin
            if (fz && z == 8'h00) begin
               if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
            end else begin
               sb_q.push_back({m_seq, z});
               m_seq = m_seq + 4'd1;
            end
         end
      end
   endtask

   task automatic push(input logic [7:0] z, input logic fz, input logic ordy);
      cycle(1'b0, 1'b1, z, fz, ordy);
   endtask

   task automatic idle(input logic ordy);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, ordy);
   endtask

   task automatic drain();
      for (int i = 0; i < 6; i++) idle(1'b1);
   endtask

   initial begin
      n_vec  = 0;
      n_err  = 0;
      chk_en = 1'b0;
      m_seq  = 4'd0;
      m_drop = 8'd0;
      rst = 1'b1; in_valid = 1'b0; in_z = 8'h00; filter_zero = 1'b0; out_ready = 1'b0;

      // Power-up reset, outputs unknown before it
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      chk_en = 1'b1;
      idle(1'b0);

      // Three pushes, no pop; head 0x81 tag 0, occupancy 3
      push(8'h81, 1'b0, 1'b0);
      push(8'h04, 1'b0, 1'b0);
      push(8'h10, 1'b0, 1'b0);
      idle(1'b0);
      drain();

      // Five back-to-back after reset: fifth refused, then pop in order
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      push(8'hA1, 1'b0, 1'b0);
      push(8'hA2, 1'b0, 1'b0);
      push(8'hA3, 1'b0, 1'b0);
      push(8'hA4, 1'b0, 1'b0);
      push(8'hA5, 1'b0, 1'b0);
      // Full: a pop with a concurrent push; the push is ignored
      push(8'hA6, 1'b0, 1'b1);
      push(8'hA7, 1'b0, 1'b0);
      drain();

      // Zero filtering: only 0x08 stored, two drops
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      push(8'h00, 1'b1, 1'b0);
      push(8'h08, 1'b1, 1'b0);
      push(8'h00, 1'b1, 1'b0);
      idle(1'b0);
      // Zero without filtering is a normal word
      push(8'h00, 1'b0, 1'b0);
      // Pop and filtered drop together
      push(8'h00, 1'b1, 1'b1);
      idle(1'b0);
      drain();

      // Continuous stream of 20 words, tag wraps 15 -> 0
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) push(8'h30 + 8'(i), 1'b0, 1'b1);
      drain();

      // Reset during a push with three entries held
      push(8'h55, 1'b0, 1'b0);
      push(8'h66, 1'b0, 1'b0);
      push(8'h77, 1'b0, 1'b0);
      push(8'h00, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 8'h99, 1'b0, 1'b1);
      push(8'h3C, 1'b0, 1'b0);
      idle(1'b0);
      drain();

      // Parity-relevant pattern: 0x07 then 0x03
      push(8'h07, 1'b0, 1'b0);
      push(8'h03, 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b0);
      drain();

      // Drop counter saturation
      for (int i = 0; i < 260; i++) push(8'h00, 1'b1, 1'b0);
      idle(1'b0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic [7:0] z;
         z = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         cycle(1'b0, 1'($urandom_range(0, 1)), z, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pla_br2_result_buf.md
PLA_BR2_RESULT_BUF -- requirements
Module: pla_br2_result_buf

Interface
REQ-001 Parameters: none; depth fixed at 4 entries, data width fixed at 8.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  in_z holds a result from the upstream br2 decode PLA.
REQ-005 in_z  input  8  upstream outputs z7..z0, with z0 as bit 0.
REQ-006 in_ready  output  1  buffer can accept this cycle.
REQ-007 filter_zero  input  1  when high, discard all-zero results instead of storing them.
REQ-008 out_valid  output  1  head entry valid.
REQ-009 out_z  output  8  head entry data.
REQ-010 out_seq  output  4  sequence tag of the head entry.
REQ-011 out_ready  input  1  downstream consumes the head entry.
REQ-012 drop_cnt  output  8  count of filtered all-zero results.
REQ-013 out_par  output  1  odd parity of out_z; present only with PLA_BR2_PARITY_EN.

Function
REQ-014 An input is accepted when in_valid and in_ready are both high on a rising edge.
REQ-015 in_ready is high exactly when occupancy is less than 4; it does not depend on out_ready in the same cycle, so there is no full-buffer pass-through.
REQ-016 An accepted input with in_z equal to 0x00 while filter_zero is high is dropped:
- it is not stored;
- seq is not advanced;
- drop_cnt increments, saturating at 255.
REQ-017 Any other accepted input is written at the tail with tag equal to the current seq value; seq then increments modulo 16 (15 wraps to 0).
REQ-018 A pop occurs when out_valid and out_ready are both high on a rising edge; the head advances to the next entry.
REQ-019 out_valid is high exactly when occupancy is greater than 0.
REQ-020 out_z and out_seq are driven from registered head storage; when occupancy is 0 they are 0.
REQ-021 Latency: a word stored at edge N is visible on out_valid, out_z and out_seq after edge N, i.e. in cycle N+1; there is no combinational path from in_* to out_*.
REQ-022 A simultaneous store and pop with occupancy 1 to 3 leaves occupancy unchanged; order stays FIFO.
REQ-023 A simultaneous store and pop with occupancy 0 is impossible, because out_valid is 0.
REQ-024 A simultaneous pop and filtered drop decrements occupancy by 1 and increments drop_cnt.
REQ-025 With occupancy 4, in_ready is 0 and input is ignored; a pop in that cycle makes in_ready high in the next cycle.
REQ-026 Head and tail pointers are 2-bit and wrap 3 to 0; occupancy is a separate 3-bit counter ranging 0 to 4.
REQ-027 filter_zero is sampled only on the accepting edge; changing it never affects already-stored entries.

Reset
REQ-028 While rst is high at a rising edge, the following are cleared to 0: occupancy, head, tail, seq and drop_cnt; in the next cycle out_valid=0, out_z=0x00, out_seq=0, in_ready=1.
REQ-029 Reset asserted mid-operation discards all stored entries; any handshake in that cycle is ignored.
REQ-030 Storage array contents need not be cleared, but out_z must still read 0 while empty.

Configuration
REQ-031 Macro PLA_BR2_PARITY_EN:
- when defined, each entry stores a ninth bit equal to the XOR of its 8 data bits, computed at write;
- out_par presents that bit for the head entry and is 0 when empty.
REQ-032 Without PLA_BR2_PARITY_EN, the out_par port and the parity storage are absent; all other behaviour is identical.

Verification
REQ-033 Reset, then push 0x81, 0x04, 0x10 with out_ready=0 -> out_valid=1, out_z=0x81, out_seq=0, occupancy 3, in_ready=1.
REQ-034 Push 5 words back-to-back with out_ready=0 -> 5th word refused (in_ready=0 after the 4th); then pop 4 -> data and tags in order 0,1,2,3.
REQ-035 filter_zero=1, push 0x00, 0x08, 0x00 -> only 0x08 stored with out_seq=0; drop_cnt=2.
REQ-036 Continuous push and pop with out_ready=1 for 20 words -> out_seq wraps 15 to 0 and occupancy stays at 1 after the first word.
REQ-037 Buffer holding 3 entries, assert rst for 1 cycle during a push -> out_valid=0, drop_cnt=0, and the next push appears with out_seq=0.
REQ-038 With PLA_BR2_PARITY_EN, push 0x07 then 0x03 -> out_par=1, then 0 after the pop.
